npcnn_result_collector: RTL and testbench
=========================================

Name: npcnn_result_collector

Overview:
- Consumer end of the convolution engine's result stream. Captures each 20-bit convolution result as the engine produces it and stores one full output feature map in a local buffer, in raster order.
- On frame completion, optionally applies ReLU and drains the map to the downstream stage over a valid/ready stream, tagged with row/col coordinates.
- Sits between the convolution engine and the pooling/memory-writeback stage.

Parameters:
- a_size, 6, input map edge length (pixels)
- f_size, 3, filter edge length
- stride, 1, convolution stride
- zeropoping, 0, zero-padding per side
- relu, 1, 1 = clamp negative results to 0 on drain; 0 = pass through
- Derived, not overridable: O_SIZE = (a_size + 2*zeropoping - f_size)/stride + 1 (4 at defaults); DEPTH = O_SIZE*O_SIZE (16); AW = clog2(DEPTH); CW = clog2(O_SIZE), minimum 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: arm collector for a new frame
- in_data  in  20  signed two's-complement convolution result
- in_valid  in  1  in_data valid this cycle (engine output-latch strobe)
- in_done  in  1  engine frame-complete pulse
- out_data  out  20  result to downstream (post-ReLU when relu=1)
- out_valid  out  1  out_data/out_row/out_col valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_row  out  CW  row index of out_data
- out_col  out  CW  column index of out_data
- busy  out  1  high in COLLECT or DRAIN
- frame_done  out  1  one-cycle pulse after last drained word handshakes
- overflow  out  1  sticky: in_valid arrived with buffer full
- underrun  out  1  sticky: in_done arrived with fewer than DEPTH words stored

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wr_ptr=0, rd_ptr=0, count=0; all outputs 0. Buffer contents are don't-care.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - start -> COLLECT; wr_ptr, rd_ptr and count cleared; overflow and underrun cleared.
  - in_valid and in_done ignored.
- COLLECT:
  - in_valid with count<DEPTH: buf[wr_ptr] <= in_data; wr_ptr++ and count++ on the same edge.
  - in_valid with count==DEPTH: data dropped; overflow <= 1.
  - count reaches DEPTH, or in_done: -> DRAIN on the next edge.
  - in_done with count<DEPTH: underrun <= 1; DRAIN emits only the count stored words.
  - Same-cycle in_valid and in_done: the word is written first, then count is evaluated including it.
  - start while in COLLECT is ignored.
- DRAIN:
  - out_valid=1 from the first cycle in DRAIN while rd_ptr<count.
  - out_data = buf[rd_ptr] is combinational from the register array, so throughput is 1 word/cycle while out_ready=1.
  - out_row = rd_ptr / O_SIZE; out_col = rd_ptr % O_SIZE. Implemented as separate row/col counters: col wraps at O_SIZE-1 to 0 and increments row.
  - On handshake (out_valid & out_ready): rd_ptr++.
  - out_valid=0 holds all outputs stable; no word is skipped or duplicated.
  - Last handshake (rd_ptr==count-1): frame_done pulses next cycle, state -> IDLE, out_valid drops that same cycle.
  - count==0 on entry (in_done with no data): frame_done pulses the next cycle, no words are emitted, -> IDLE.
  - in_valid in DRAIN: dropped; overflow <= 1. start in DRAIN is ignored.
- Latency: last input write to first out_valid = 1 cycle. For DEPTH=16 with out_ready held high, the first word appears 1 cycle after the 16th write and frame_done pulses 17 cycles after that write.
- ReLU (relu=1): out_data = in_data[19] ? 0 : in_data. It is applied on the read path only; stored values are unmodified.
- Flags: overflow and underrun are sticky until the next accepted start or reset.
- Reset mid-operation: immediate return to IDLE; the partial frame is discarded; no frame_done pulse.

Decomposition:
- Shared package npcnn_pkg: RES_W=20 and state encoding IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2. The O_SIZE computation is provided as a constant function so the engine and collector agree.
- One sub-module, npcnn_result_buf: a DEPTH x 20 register array with one synchronous write port and one combinational read port. FSM, counters and ReLU live in the top.

Test Plan:
- Full frame at defaults: start, then 16 in_valid with in_data=k (k=0..15), out_ready=1 -> out_data 0..15 on consecutive cycles; (row,col) runs (0,0)..(3,3) and wraps col 3->0 at k=4,8,12; frame_done 17 cycles after the last write; overflow=0, underrun=0.
- ReLU: in_data=20'hFFFF0 (-16) at position 5, others 7, relu=1 -> word 5 drains as 0 and the rest as 7. With relu=0, word 5 drains as 20'hFFFF0.
- Backpressure: toggle out_ready 1,0,0,1,... during drain -> each word appears exactly once, held stable while out_ready=0; 16 handshakes total, then frame_done.
- Overflow/underrun: a 17th in_valid after the 16th write -> overflow=1, the extra word is absent from the drain. Separately, in_done after 10 words -> underrun=1, exactly 10 words drained, frame_done after the 10th.
- Reset mid-drain: assert reset low after 6 handshakes -> out_valid=0, busy=0 immediately; after a new start and frame, the drain begins at (0,0) with the new data.
- start during COLLECT at word 8 -> ignored; wr_ptr continues to 16 and the drain contains the original 16 words.

Source files
------------

// File: rtl/npcnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npcnn_pkg
// Purpose  : Shared widths, state encoding and output-size helper for the CNN.
// Revision : 1.0
// ============================================================================
package npcnn_pkg;

    localparam int RES_W = 20;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // Output feature-map edge; engine and collector must agree on this.
    function automatic int o_size_f(input int a_size, input int f_size,
                                    input int stride, input int pad);
        return (a_size + 2 * pad - f_size) / stride + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/npcnn_result_buf.sv
`default_nettype none
// ============================================================================
// Module   : npcnn_result_buf
// Purpose  : DEPTH x W register array, one synchronous write, one async read.
// Revision : 1.0
// ============================================================================
module npcnn_result_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 20
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/npcnn_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : npcnn_result_collector
// Purpose  : Buffers one output feature map, then drains it (optional ReLU)
//            over valid/ready with row/col tags.
// Revision : 1.0
// ============================================================================
module npcnn_result_collector
    import npcnn_pkg::*;
#(
    parameter int a_size     = 6,
    parameter int f_size     = 3,
    parameter int stride     = 1,
    parameter int zeropoping = 0,
    parameter int relu       = 1,
    localparam int O_SIZE = o_size_f(a_size, f_size, stride, zeropoping),
    localparam int DEPTH  = O_SIZE * O_SIZE,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = (O_SIZE > 1) ? $clog2(O_SIZE) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RES_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_done,
    output logic [RES_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow,
    output logic             underrun
);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q;
    logic [CNT_W-1:0] count_q, rd_ptr_q;
    logic [CW-1:0]    row_q, col_q;
    logic             frame_done_q, overflow_q, underrun_q;

    logic             w_wr, w_hs, w_last, w_drain_end;
    logic [CNT_W-1:0] w_cnt_next;
    logic [RES_W-1:0] w_rd;

    assign w_wr        = (state_q == ST_COLLECT) && in_valid && (count_q < CNT_W'(DEPTH));
    assign w_cnt_next  = count_q + CNT_W'(w_wr);
    assign w_hs        = out_valid && out_ready;
    assign w_last      = w_hs && (rd_ptr_q == count_q - CNT_W'(1));
    assign w_drain_end = (count_q == '0) || w_last;

    npcnn_result_buf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (RES_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (w_wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (w_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_COLLECT;
            ST_COLLECT: if ((count_q == CNT_W'(DEPTH)) || in_done) state_d = ST_DRAIN;
            ST_DRAIN:   if (w_drain_end) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
        out_valid = (state_q == ST_DRAIN) && (rd_ptr_q < count_q);
        out_data  = '0;
        if (out_valid) begin
            out_data = ((relu != 0) && w_rd[RES_W-1]) ? '0 : w_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        count_q    <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        overflow_q <= 1'b0;
                        underrun_q <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (w_wr) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        count_q  <= w_cnt_next;
                    end
                    if (in_valid && !w_wr) overflow_q <= 1'b1;
                    // The same-cycle word counts toward a complete frame.
                    if (in_done && (w_cnt_next < CNT_W'(DEPTH))) underrun_q <= 1'b1;
                end
                ST_DRAIN: begin
                    if (in_valid) overflow_q <= 1'b1;
                    if (w_hs) begin
                        rd_ptr_q <= rd_ptr_q + CNT_W'(1);
                        if (col_q == CW'(O_SIZE - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + CW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                    if (w_drain_end) frame_done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_row    = row_q;
    assign out_col    = col_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_npcnn_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_npcnn_result_collector
// Purpose  : Scoreboard bench; ReLU and pass-through instances share stimulus.
// Revision : 1.0
// ============================================================================
module tb_npcnn_result_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [19:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_done = 1'b0;
    logic        out_ready = 1'b1;

    logic [19:0] od1, od0;
    logic        ov1, ov0, busy1, busy0, fd1, fd0, ovf1, ovf0, und1, und0;
    logic [1:0]  or1, oc1, or0, oc0;

    logic [23:0] q1[$];
    logic [23:0] q0[$];
    logic [23:0] tmp;
    int nvec = 0;
    int nerr = 0;
    int hs1  = 0;
    int n;

    always #5 clk = ~clk;

    npcnn_result_collector #(.relu(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_done(in_done), .out_data(od1), .out_valid(ov1),
        .out_ready(out_ready), .out_row(or1), .out_col(oc1), .busy(busy1),
        .frame_done(fd1), .overflow(ovf1), .underrun(und1)
    );

    npcnn_result_collector #(.relu(0)) u_dut_nr (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_done(in_done), .out_data(od0), .out_valid(ov0),
        .out_ready(out_ready), .out_row(or0), .out_col(oc0), .busy(busy0),
        .frame_done(fd0), .overflow(ovf0), .underrun(und0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word for each instance: {data, row, col}.
    task automatic push_exp(input logic [19:0] d, input int idx);
        logic [1:0] r, c;
        r = 2'(idx / 4);
        c = 2'(idx % 4);
        q1.push_back({(d[19] ? 20'h0 : d), r, c});
        q0.push_back({d, r, c});
    endtask

    task automatic write_word(input logic [19:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_done();
        in_done = 1'b1;
        @(posedge clk); #1;
        in_done = 1'b0;
    endtask

    task automatic wait_done(input bit bp, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            out_ready = bp ? (cycles % 3 == 0) : 1'b1;
        end while (!fd1 && cycles < 200);
        out_ready = 1'b1;
        if (!fd1) begin
            nvec++; nerr++;
            $display("FAIL frame_done_timeout: got no pulse within %0d cycles", cycles);
        end
    endtask

    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL extra_word_relu: got %h expected no word", {od1, or1, oc1});
            end else begin
                chk(out_ready ? "drain_relu" : "hold_relu", {8'h0, od1, or1, oc1}, {8'h0, q1[0]});
                if (out_ready) begin
                    tmp = q1.pop_front();
                    hs1++;
                end
            end
        end
        if (ov0 === 1'b1) begin
            if (q0.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL extra_word_pass: got %h expected no word", {od0, or0, oc0});
            end else begin
                chk(out_ready ? "drain_pass" : "hold_pass", {8'h0, od0, or0, oc0}, {8'h0, q0[0]});
                if (out_ready) tmp = q0.pop_front();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {od1, ov1, busy1, fd1, ovf1, und1, or1, oc1},
            {20'h0, 5'b0, 4'b0});
        reset = 1'b1;
        @(posedge clk); #1;

        // Full frame, ramp data
        start_frame();
        for (int k = 0; k < 16; k++) begin
            push_exp(20'(k), k);
            write_word(20'(k));
        end
        wait_done(1'b0, n);
        chk("fd_latency_full", n, 17);
        chk("flags_full", {ovf1, und1, busy1}, 3'b000);
        chk("queue_empty_full", q1.size(), 0);

        // Negative word at position 5
        start_frame();
        for (int k = 0; k < 16; k++) begin
            push_exp((k == 5) ? 20'hFFFF0 : 20'd7, k);
            write_word((k == 5) ? 20'hFFFF0 : 20'd7);
        end
        wait_done(1'b0, n);
        chk("fd_latency_relu", n, 17);
        chk("queue_empty_pass", q0.size(), 0);

        // Backpressure
        hs1 = 0;
        start_frame();
        for (int k = 0; k < 16; k++) begin
            push_exp(20'(3 * k + 1), k);
            write_word(20'(3 * k + 1));
        end
        wait_done(1'b1, n);
        chk("handshakes_bp", hs1, 16);
        chk("queue_empty_bp", q1.size(), 0);

        // Overflow: 17th word dropped
        start_frame();
        for (int k = 0; k < 16; k++) begin
            push_exp(20'(k + 40), k);
            write_word(20'(k + 40));
        end
        write_word(20'h00099);
        wait_done(1'b0, n);
        chk("fd_latency_ovf", n, 16);
        chk("flags_ovf", {ovf1, und1}, 2'b10);

        // Underrun after 10 words
        hs1 = 0;
        start_frame();
        for (int k = 0; k < 10; k++) begin
            push_exp(20'(k + 60), k);
            write_word(20'(k + 60));
        end
        pulse_done();
        wait_done(1'b0, n);
        chk("fd_latency_und", n, 10);
        chk("words_und", hs1, 10);
        chk("flags_und", {ovf1, und1}, 2'b01);

        // Empty frame
        start_frame();
        pulse_done();
        wait_done(1'b0, n);
        chk("fd_latency_empty", n, 1);
        chk("flags_empty", {ovf1, und1}, 2'b01);

        // Reset mid-drain after 6 handshakes
        hs1 = 0;
        start_frame();
        for (int k = 0; k < 16; k++) begin
            push_exp(20'(k + 80), k);
            write_word(20'(k + 80));
        end
        n = 0;
        while (hs1 < 6 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hs_before_reset", hs1, 6);
        reset = 1'b0;
        #1;
        chk("reset_mid_drain", {ov1, busy1, fd1}, 3'b000);
        q1.delete();
        q0.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        start_frame();
        for (int k = 0; k < 16; k++) begin
            push_exp(20'(k + 100), k);
            write_word(20'(k + 100));
        end
        wait_done(1'b0, n);
        chk("fd_latency_after_reset", n, 17);

        // start during COLLECT at word 8 is ignored
        start_frame();
        for (int k = 0; k < 16; k++) begin
            push_exp(20'(k + 200), k);
            if (k == 8) start = 1'b1;
            write_word(20'(k + 200));
        end
        wait_done(1'b0, n);
        chk("fd_latency_start_ign", n, 17);
        chk("queue_empty_start_ign", q1.size(), 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
